// File: rtl/m_axil_cmd_master.sv
// AXI4-Lite master: turns a single-beat command/response stream into AXI-Lite
// read and write transactions, one transaction outstanding at a time.
//
// state     | meaning
// ----------+-------------------------------------------------
// S_IDLE    | ready for a command (CMD_READY high)
// S_WR      | AW and W offered, waiting for both handshakes
// S_WR_RESP | BREADY high, waiting for the write response
// S_RD_ADDR | AR offered, waiting for ARREADY
// S_RD_DATA | RREADY high, waiting for read data
// S_RSP     | response held on RSP_* until RSP_READY
module m_axil_cmd_master #(
    parameter int M_AXI_ADDR_WIDTH = 6,
    parameter int M_AXI_DATA_WIDTH = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            CMD_VALID,
    output logic                            CMD_READY,
    input  logic                            CMD_WRITE,
    input  logic [M_AXI_ADDR_WIDTH-1:0]     CMD_ADDR,
    input  logic [M_AXI_DATA_WIDTH-1:0]     CMD_WDATA,
    input  logic [M_AXI_DATA_WIDTH/8-1:0]   CMD_WSTRB,
    output logic                            RSP_VALID,
    input  logic                            RSP_READY,
    output logic                            RSP_WRITE,
    output logic [M_AXI_DATA_WIDTH-1:0]     RSP_RDATA,
    output logic [1:0]                      RSP_RESP,
    output logic                            BUSY,
    output logic [M_AXI_ADDR_WIDTH-1:0]     AWADDR,
    output logic                            AWVALID,
    input  logic                            AWREADY,
    output logic [M_AXI_DATA_WIDTH-1:0]     WDATA,
    output logic [M_AXI_DATA_WIDTH/8-1:0]   WSTRB,
    output logic                            WVALID,
    input  logic                            WREADY,
    input  logic [1:0]                      BRESP,
    input  logic                            BVALID,
    output logic                            BREADY,
    output logic [M_AXI_ADDR_WIDTH-1:0]     ARADDR,
    output logic                            ARVALID,
    input  logic                            ARREADY,
    input  logic [M_AXI_DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                      RRESP,
    input  logic                            RVALID,
    output logic                            RREADY
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RSP
    } state_t;

    state_t                          state_q, state_d;
    logic                            cmd_ready_q, cmd_ready_d;
    logic                            awvalid_q, awvalid_d;
    logic                            wvalid_q, wvalid_d;
    logic                            bready_q, bready_d;
    logic                            arvalid_q, arvalid_d;
    logic                            rready_q, rready_d;
    logic                            rsp_valid_q, rsp_valid_d;
    logic                            rsp_write_q, rsp_write_d;
    logic [M_AXI_ADDR_WIDTH-1:0]     awaddr_q, awaddr_d;
    logic [M_AXI_ADDR_WIDTH-1:0]     araddr_q, araddr_d;
    logic [M_AXI_DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [M_AXI_DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic [M_AXI_DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                      rsp_resp_q, rsp_resp_d;

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            S_IDLE: begin
                if (CMD_VALID && cmd_ready_q) begin
                    if (CMD_WRITE) begin
                        state_d   = S_WR;
                        awaddr_d  = CMD_ADDR;
                        wdata_d   = CMD_WDATA;
                        wstrb_d   = CMD_WSTRB;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RD_ADDR;
                        araddr_d  = CMD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WR: begin
                // AW and W retire independently; leave once neither is pending
                awvalid_d = awvalid_q && !AWREADY;
                wvalid_d  = wvalid_q && !WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = S_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (BVALID) begin
                    state_d     = S_RSP;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = BRESP;
                end
            end
            S_RD_ADDR: begin
                if (ARREADY) begin
                    state_d   = S_RD_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            S_RD_DATA: begin
                if (RVALID) begin
                    state_d     = S_RSP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = RDATA;
                    rsp_resp_d  = RRESP;
                end
            end
            S_RSP: begin
                if (RSP_READY) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // registered so a new command is only offered the cycle after the response retires
        cmd_ready_d = (state_d == S_IDLE);
    end

    assign CMD_READY = cmd_ready_q;
    assign BUSY      = (state_q != S_IDLE);
    assign AWVALID   = awvalid_q;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_WRITE = rsp_write_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_RESP  = rsp_resp_q;
    assign AWADDR    = awaddr_q;
    assign ARADDR    = araddr_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;

endmodule

// File: tb/tb_m_axil_cmd_master.sv
// Bench for m_axil_cmd_master: register-file slave, transaction-level model
// with a per-cycle compare process, and directed command sequences.
module tb_m_axil_cmd_master;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic        CMD_WRITE = 1'b0;
    logic [5:0]  CMD_ADDR = '0;
    logic [31:0] CMD_WDATA = '0;
    logic [3:0]  CMD_WSTRB = '0;
    logic        RSP_VALID;
    logic        RSP_READY = 1'b1;
    logic        RSP_WRITE;
    logic [31:0] RSP_RDATA;
    logic [1:0]  RSP_RESP;
    logic        BUSY;
    logic [5:0]  AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [5:0]  ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    always #5 ACLK = ~ACLK;

    m_axil_cmd_master #(.M_AXI_ADDR_WIDTH(6), .M_AXI_DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_WRITE(RSP_WRITE),
        .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP), .BUSY(BUSY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- slave: simple register file ----------------
    logic [31:0] s_mem [16];
    int          aw_stall = 0;
    logic [1:0]  slave_resp = 2'b00;
    bit          r_hold = 1'b0;
    int          aw_cnt;
    logic        aw_got, w_got, have_aw, have_w;
    logic [5:0]  aw_l, sl_a;
    logic [31:0] wd_l, sl_d, sl_tmp;
    logic [3:0]  ws_l, sl_s;

    assign AWREADY = AWVALID && (aw_cnt >= aw_stall);
    assign WREADY  = WVALID;
    assign ARREADY = ARVALID;

    always @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            aw_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            aw_l <= '0; wd_l <= '0; ws_l <= '0;
            BVALID <= 1'b0; BRESP <= '0;
            RVALID <= 1'b0; RDATA <= '0; RRESP <= '0;
        end else begin
            have_aw = aw_got || (AWVALID && AWREADY);
            have_w  = w_got || (WVALID && WREADY);
            sl_a = aw_got ? aw_l : AWADDR;
            sl_d = w_got ? wd_l : WDATA;
            sl_s = w_got ? ws_l : WSTRB;
            aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
            if (AWVALID && AWREADY) begin aw_got <= 1'b1; aw_l <= AWADDR; end
            if (WVALID && WREADY) begin w_got <= 1'b1; wd_l <= WDATA; ws_l <= WSTRB; end
            if (BVALID && BREADY) BVALID <= 1'b0;
            if (have_aw && have_w) begin
                sl_tmp = s_mem[sl_a[5:2]];
                for (int b = 0; b < 4; b++)
                    if (sl_s[b]) sl_tmp[8*b +: 8] = sl_d[8*b +: 8];
                s_mem[sl_a[5:2]] = sl_tmp;
                BVALID <= 1'b1; BRESP <= slave_resp;
                aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (RVALID && RREADY) RVALID <= 1'b0;
            if (ARVALID && ARREADY && !r_hold) begin
                RVALID <= 1'b1; RDATA <= s_mem[ARADDR[5:2]]; RRESP <= slave_resp;
            end
        end
    end

    // ---------------- transaction-level model ----------------
    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          hold;
        int          aw_stall;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [16];
    int          b_hs = 0, rsp_count = 0, wr_issued = 0, cmd_issued = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    // ---------------- per-cycle compare process ----------------
    int          aw_cyc = 0, w_cyc = 0, stall_cyc = 0;
    logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic        p_rspv = 0, p_rspr = 0, p_rsp_hs = 0;
    logic [5:0]  p_awaddr = '0, p_araddr = '0;
    logic [35:0] p_w = '0;
    logic [34:0] p_rsp = '0;
    exp_t        cur;

    always @(negedge ACLK) begin
        if (!ARESET) begin
            exp_q.delete();
            aw_cyc = 0; w_cyc = 0; stall_cyc = 0;
            p_awv = 0; p_wv = 0; p_arv = 0; p_rspv = 0; p_rsp_hs = 0;
        end else begin
            if (CMD_READY) check("cmd_ready_implies_idle", BUSY, 0);
            if (RSP_VALID) check("no_cmd_rsp_overlap", CMD_READY, 0);
            if (p_rsp_hs) check("cmd_ready_after_rsp", CMD_READY, 1);
            if (BREADY) check("bready_after_aw_w", {AWVALID, WVALID}, 0);
            if (p_awv && !p_awr) check("aw_stable", {AWVALID, AWADDR}, {1'b1, p_awaddr});
            if (p_wv && !p_wr) check("w_stable", {WVALID, WDATA, WSTRB}, {1'b1, p_w});
            if (p_arv && !p_arr) check("ar_stable", {ARVALID, ARADDR}, {1'b1, p_araddr});
            if (p_rspv && !p_rspr)
                check("rsp_stable", {RSP_VALID, RSP_WRITE, RSP_RDATA, RSP_RESP}, {1'b1, p_rsp});

            if (AWVALID) aw_cyc++;
            if (WVALID) w_cyc++;
            if (RSP_VALID && !RSP_READY) stall_cyc++;

            if (AWVALID && AWREADY) begin
                if (exp_q.size() == 0) check("aw_expected", 0, 1);
                else begin
                    check("aw_addr", AWADDR, exp_q[0].addr);
                    check("aw_valid_cycles", aw_cyc, exp_q[0].aw_stall + 1);
                end
                aw_cyc = 0;
            end
            if (WVALID && WREADY) begin
                if (exp_q.size() == 0) check("w_expected", 0, 1);
                else check("w_data_strb", {WDATA, WSTRB}, {exp_q[0].wdata, exp_q[0].wstrb});
                check("w_valid_cycles", w_cyc, 1);
                w_cyc = 0;
            end
            if (ARVALID && ARREADY) begin
                if (exp_q.size() == 0) check("ar_expected", 0, 1);
                else check("ar_addr", ARADDR, exp_q[0].addr);
            end
            if (BVALID && BREADY) b_hs++;
            if (RSP_VALID && RSP_READY) begin
                if (exp_q.size() == 0) check("rsp_expected", 0, 1);
                else begin
                    cur = exp_q.pop_front();
                    check("rsp_write", RSP_WRITE, cur.wr);
                    check("rsp_rdata", RSP_RDATA, cur.rdata);
                    check("rsp_resp", RSP_RESP, cur.resp);
                    check("rsp_stall_cycles", stall_cyc, cur.hold);
                end
                stall_cyc = 0;
                rsp_count++;
            end

            p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
            p_wv = WVALID; p_wr = WREADY; p_w = {WDATA, WSTRB};
            p_arv = ARVALID; p_arr = ARREADY; p_araddr = ARADDR;
            p_rspv = RSP_VALID; p_rspr = RSP_READY;
            p_rsp = {RSP_WRITE, RSP_RDATA, RSP_RESP};
            p_rsp_hs = RSP_VALID && RSP_READY;
        end
    end

    // ---------------- command driver ----------------
    task automatic do_cmd(input bit wr, input logic [5:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [1:0] resp, input int hold,
                          output logic [31:0] got_rdata, output logic [1:0] got_resp,
                          output int lat);
        exp_t e;
        bit   ok;
        int   hs_cyc;
        e.wr = wr; e.addr = addr; e.wdata = wd; e.wstrb = ws;
        e.resp = resp; e.hold = hold; e.aw_stall = aw_stall;
        e.rdata = wr ? 32'h0 : ref_mem[addr[5:2]];
        if (wr) ref_mem[addr[5:2]] = merge(ref_mem[addr[5:2]], wd, ws);
        got_rdata = '0; got_resp = '0; lat = -1; hs_cyc = 0;
        slave_resp = resp;
        RSP_READY = (hold == 0);
        exp_q.push_back(e);
        cmd_issued++;
        if (wr) wr_issued++;
        CMD_WRITE = wr; CMD_ADDR = addr; CMD_WDATA = wd; CMD_WSTRB = ws; CMD_VALID = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge ACLK);
            if (CMD_READY) begin ok = 1'b1; hs_cyc = cyc; end
        end
        check("cmd_accept_in_time", ok, 1);
        @(posedge ACLK); #1;
        CMD_VALID = 1'b0;
        if (!ok) return;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge ACLK);
            if (RSP_VALID) begin
                ok = 1'b1;
                lat = cyc - hs_cyc;
                got_rdata = RSP_RDATA;
                got_resp = RSP_RESP;
            end
        end
        check("rsp_in_time", ok, 1);
        if (!ok) begin RSP_READY = 1'b1; return; end
        repeat (hold) begin @(posedge ACLK); #1; end
        RSP_READY = 1'b1;
        @(posedge ACLK); #1;
    endtask

    logic [31:0] rd;
    logic [1:0]  rs;
    int          lat, b0, r0;
    bit          ok;

    initial begin
        for (int i = 0; i < 16; i++) begin
            logic [7:0] bv;
            bv = 8'(i);
            s_mem[i] = {4{bv}};
            ref_mem[i] = {4{bv}};
        end
        s_mem[2] = 32'h11223344;
        ref_mem[2] = 32'h11223344;

        #1 ARESET = 1'b0;
        #1;
        check("reset_handshake_outs",
              {AWVALID, WVALID, ARVALID, BREADY, RREADY, RSP_VALID, CMD_READY, BUSY}, 0);
        check("reset_addr_fields", {AWADDR, ARADDR, WSTRB, RSP_RESP, RSP_WRITE}, 0);
        check("reset_data_fields", {WDATA, RSP_RDATA}, 0);
        repeat (2) @(negedge ACLK);
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        check("cmd_ready_after_reset", CMD_READY, 1);

        // basic write then read-back, zero-wait latency
        do_cmd(1'b1, 6'h04, 32'hDEADBEEF, 4'hF, 2'b00, 0, rd, rs, lat);
        check("t1_rdata", rd, 32'h0);
        check("t1_resp", rs, 2'b00);
        check("t1_latency", lat, 3);
        do_cmd(1'b0, 6'h04, 32'h0, 4'h0, 2'b00, 0, rd, rs, lat);
        check("t2_rdata", rd, 32'hDEADBEEF);
        check("t2_latency", lat, 3);

        // AWREADY stalled 3 cycles, WREADY immediate
        aw_stall = 3;
        b0 = b_hs;
        do_cmd(1'b1, 6'h0C, 32'hA5A5A5A5, 4'hF, 2'b00, 0, rd, rs, lat);
        aw_stall = 0;
        check("t3_single_b", b_hs - b0, 1);
        check("t3_rdata_zero", rd, 32'h0);
        check("t3_latency", lat, 6);

        // partial write keeps the untouched bytes
        do_cmd(1'b1, 6'h08, 32'h0000CAFE, 4'h3, 2'b00, 0, rd, rs, lat);
        do_cmd(1'b0, 6'h08, 32'h0, 4'h0, 2'b00, 0, rd, rs, lat);
        check("t4_partial_rdata", rd, 32'h1122CAFE);

        // response back-pressure for 4 cycles
        do_cmd(1'b0, 6'h0C, 32'h0, 4'h0, 2'b00, 4, rd, rs, lat);
        check("t5_rdata", rd, 32'hA5A5A5A5);
        check("t5_latency", lat, 3);

        // error codes, upper-byte strobes, unaligned address
        do_cmd(1'b1, 6'h14, 32'h01234567, 4'hC, 2'b00, 0, rd, rs, lat);
        do_cmd(1'b0, 6'h14, 32'h0, 4'h0, 2'b00, 0, rd, rs, lat);
        check("upper_strobe_rdata", rd, 32'h01230505);
        do_cmd(1'b1, 6'h3C, 32'h12345678, 4'hF, 2'b11, 0, rd, rs, lat);
        check("decerr_write_resp", rs, 2'b11);
        do_cmd(1'b0, 6'h08, 32'h0, 4'h0, 2'b10, 0, rd, rs, lat);
        check("slverr_read_resp", rs, 2'b10);
        check("slverr_read_rdata", rd, 32'h1122CAFE);
        do_cmd(1'b0, 6'h06, 32'h0, 4'h0, 2'b00, 0, rd, rs, lat);
        check("unaligned_rdata", rd, 32'hDEADBEEF);

        // reset while waiting in the read-data phase
        begin
            exp_t e;
            e.wr = 1'b0; e.addr = 6'h08; e.wdata = '0; e.wstrb = '0;
            e.rdata = ref_mem[2]; e.resp = 2'b00; e.hold = 0; e.aw_stall = 0;
            exp_q.push_back(e);
        end
        r_hold = 1'b1;
        r0 = rsp_count;
        CMD_WRITE = 1'b0; CMD_ADDR = 6'h08; CMD_VALID = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge ACLK);
            if (CMD_READY) ok = 1'b1;
        end
        @(posedge ACLK); #1;
        CMD_VALID = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge ACLK);
            if (RREADY) ok = 1'b1;
        end
        check("t6_reached_rd_data", ok, 1);
        repeat (2) @(negedge ACLK);
        #2;
        check("t6_in_rd_data", {BUSY, RREADY}, 2'b11);
        ARESET = 1'b0;
        #1;
        check("t6_async_reset_outs",
              {AWVALID, WVALID, ARVALID, BREADY, RREADY, RSP_VALID, CMD_READY, BUSY}, 0);
        check("t6_async_reset_fields", {ARADDR, RSP_RDATA, RSP_RESP, RSP_WRITE}, 0);
        r_hold = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESET = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        check("t6_no_response", rsp_count - r0, 0);
        do_cmd(1'b0, 6'h04, 32'h0, 4'h0, 2'b00, 0, rd, rs, lat);
        check("t6_recover_rdata", rd, 32'hDEADBEEF);
        check("t6_recover_latency", lat, 3);

        repeat (3) @(posedge ACLK);
        #1;
        check("all_responses_consumed", exp_q.size(), 0);
        check("response_count", rsp_count, cmd_issued);
        check("b_handshake_count", b_hs, wr_issued);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/m_axil_cmd_master.md
Name: m_axil_cmd_master

Overview:
Synthesizable AXI4-Lite master that converts a simple single-beat command/response stream into AXI-Lite read and write transactions. It sits directly upstream of s_axil_register and drives its AW/W/B/AR/R channels. It replaces the behavioural master BFM in hardware: a controller or sequencer issues register accesses through the command port. One transaction is outstanding at a time.

Parameters:
M_AXI_ADDR_WIDTH, 6, AXI address width; also the CMD_ADDR width.
M_AXI_DATA_WIDTH, 32, AXI data width, a multiple of 8; WSTRB width is M_AXI_DATA_WIDTH/8.

Ports:
ACLK  in  1  clock; all logic on the rising edge.
ARESET  in  1  asynchronous, active-low reset.
CMD_VALID  in  1  command valid.
CMD_READY  out  1  command accepted when high together with CMD_VALID.
CMD_WRITE  in  1  1 = write, 0 = read.
CMD_ADDR  in  M_AXI_ADDR_WIDTH  byte address.
CMD_WDATA  in  M_AXI_DATA_WIDTH  write data.
CMD_WSTRB  in  M_AXI_DATA_WIDTH/8  write byte strobes.
RSP_VALID  out  1  response valid.
RSP_READY  in  1  response consumed.
RSP_WRITE  out  1  response belongs to a write.
RSP_RDATA  out  M_AXI_DATA_WIDTH  read data; 0 for writes.
RSP_RESP  out  2  BRESP or RRESP of the transaction.
BUSY  out  1  high in every state except IDLE.
AWADDR, AWVALID, AWREADY, WDATA, WVALID, WREADY, WSTRB, BRESP, BVALID, BREADY, ARADDR, ARVALID, ARREADY, RDATA, RRESP, RVALID, RREADY  AXI4-Lite master side, standard directions and widths.

Behaviour:
- Clock and reset: one clock, ACLK. ARESET is asynchronous and active-low.
- Reset (ARESET low, asynchronous): state = IDLE.
  - All VALID/READY outputs = 0; BUSY = 0.
  - AWADDR, ARADDR, WDATA, WSTRB, RSP_RDATA, RSP_RESP, RSP_WRITE = 0.
  - Reset mid-transaction abandons it immediately; no response is produced.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - CMD_READY = 1; all other outputs are registered and change only on a clock edge.
  - On CMD_VALID && CMD_READY, capture addr, data, strobe and write into registers.
  - Write command: go to WR; AWVALID = WVALID = 1 in the next cycle.
  - Read command: go to RD_ADDR; ARVALID = 1 in the next cycle.
- WR:
  - AWVALID clears on the edge where AWVALID && AWREADY; WVALID clears on the edge where WVALID && WREADY.
  - The two handshakes are independent and may occur in either order or the same cycle.
  - Move to WR_RESP once both have completed, including when the last completes this cycle.
  - AWADDR, WDATA and WSTRB stay stable while their VALID is high.
- WR_RESP: BREADY = 1. On BVALID, capture BRESP, set RSP_WRITE = 1 and RSP_RDATA = 0, then go to RSP with BREADY = 0.
- RD_ADDR: ARVALID held high with ARADDR stable; on ARREADY, clear ARVALID and go to RD_DATA.
- RD_DATA: RREADY = 1. On RVALID, capture RDATA and RRESP, set RSP_WRITE = 0, then go to RSP with RREADY = 0.
- RSP:
  - RSP_VALID = 1, with RSP_* stable until RSP_READY.
  - On RSP_VALID && RSP_READY, go to IDLE with RSP_VALID = 0.
  - CMD_READY rises in the following cycle, so there is no command/response overlap.
- VALID never depends combinationally on READY; no output has a combinational path from any input.
- AXI channel rules:
  - Any VALID, once asserted, stays high until its handshake completes.
  - BVALID arriving before both AW and W complete is not acknowledged; it stays pending for WR_RESP.
- Pass-through fields:
  - RSP_RESP codes are passed through unmodified, including SLVERR and DECERR.
  - CMD_ADDR is passed through unaligned; the slave handles alignment.
- Minimum latency with zero-wait slave, counted from the command handshake edge:
  - Write: AW/W high 1 cycle later, BREADY 2 cycles later, RSP_VALID 3 cycles later.
  - Read: same timing with AR in place of AW/W and RREADY in place of BREADY.
- Back-to-back throughput: one transaction per 5 cycles minimum.

Test Plan:
1. Reset then write addr 0x04, data 0xDEADBEEF, strb 0xF to s_axil_register -> AWADDR=0x04 and WDATA=0xDEADBEEF while VALID; RSP_VALID with RSP_WRITE=1, RSP_RESP=0, RSP_RDATA=0.
2. Read addr 0x04 after test 1 -> ARADDR=0x04; RSP_RDATA=0xDEADBEEF, RSP_RESP=0, RSP_WRITE=0.
3. Slave stalls: AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle; AWVALID and AWADDR held stable 3 cycles; single B accepted; exactly one response.
4. Partial write strb 0x3 with data 0x0000CAFE to 0x08, which holds 0x11223344 -> read of 0x08 returns 0x1122CAFE.
5. RSP_READY held low 4 cycles -> RSP_VALID and RSP_* stable for 4 cycles; CMD_READY stays 0 until 1 cycle after the response handshake.
6. ARESET driven low while in RD_DATA -> all VALID/READY outputs 0 immediately, asynchronously; no RSP_VALID; after release, the next command completes normally.
